data_mem_unit: RTL and testbench

DATA_MEM_UNIT -- requirements
Module: data_mem_unit

---
 rtl/data_mem_unit_pkg.sv | 42 ++++
 rtl/data_mem_unit_dm_ram.sv | 25 ++
 rtl/data_mem_unit.sv | 156 +++++++++++++++
 tb/tb_data_mem_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_unit_pkg.sv
// Shared encodings for the data memory unit: load types, store size masks,
// FSM states, and small decode helpers.
package data_mem_unit_pkg;

  // func3 load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // dm_w_en size masks (unshifted)
  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPLIT = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Byte-lane footprint of a load, so loads and stores share the split logic.
  function automatic logic [3:0] load_mask(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: load_mask = MASK_BYTE;
      F3_LH, F3_LHU: load_mask = MASK_HALF;
      default:       load_mask = MASK_WORD;
    endcase
  endfunction

  function automatic logic legal_store(input logic [3:0] m);
    legal_store = (m == MASK_BYTE) || (m == MASK_HALF) || (m == MASK_WORD);
  endfunction

  function automatic logic legal_load(input logic [2:0] f3);
    legal_load = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                 (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/data_mem_unit_dm_ram.sv
// Single-port, word-wide synchronous RAM with per-byte write enables.
// Read-before-write: q shows the word as it was before a same-cycle write.
module dm_ram #(
  parameter int WORDS_W = 10
) (
  input  logic               clk,
  input  logic [WORDS_W-1:0] addr,
  input  logic [3:0]         we,
  input  logic [31:0]        wdata,
  output logic [31:0]        q
);

  logic [31:0] mem [0:(1 << WORDS_W) - 1];

  // Byte-lane writes and registered read of the addressed word.
  // NOTE: the array has no reset branch; resetting a memory turns it into
  // thousands of flops instead of a RAM macro.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/data_mem_unit.sv
// Data memory access unit: byte/half/word loads and stores on a word RAM,
// with misaligned accesses split over two consecutive words.
module data_mem_unit
  import data_mem_unit_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  dm_w_en,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int WW = ADDR_W - 2;

  state_t          state;
  logic [WW-1:0]   word_q;
  logic [1:0]      off_q;
  logic [2:0]      f3_q;
  logic            store_q;
  logic            split_q;
  logic [3:0]      hi_mask_q;
  logic [31:0]     hi_data_q;
  logic [31:0]     lo_q;

  logic [WW-1:0]   ram_addr;
  logic [3:0]      ram_we;
  logic [31:0]     ram_wdata;
  logic [31:0]     ram_q;

  // Request decode: the size mask and data are moved into an 8-lane window
  // covering word W (lanes 3:0) and word W+1 (lanes 7:4).
  logic        is_store_in;
  logic        legal_in;
  logic [3:0]  size_mask;
  logic [7:0]  lane_mask;
  logic [63:0] lane_data;
  logic        split_in;
  logic        accept;
  logic        unused_addr_hi;

  assign is_store_in    = |dm_w_en;
  assign legal_in       = is_store_in ? legal_store(dm_w_en) : legal_load(func3);
  assign size_mask      = is_store_in ? dm_w_en : load_mask(func3);
  assign lane_mask      = {4'b0000, size_mask} << addr[1:0];
  assign lane_data      = {32'b0, wdata} << {addr[1:0], 3'b000};
  assign split_in       = legal_in && (|lane_mask[7:4]);
  assign accept         = req_valid && req_ready && !rst;
  assign unused_addr_hi = ^addr[31:ADDR_W];

  // RAM port steering: word W from live inputs at accept, word W+1 from
  // registered fields in SPLIT; a reset in SPLIT suppresses the second write.
  // NOTE: every output of this block gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    ram_addr  = word_q;
    ram_we    = 4'b0000;
    ram_wdata = hi_data_q;
    case (state)
      IDLE: begin
        ram_addr  = addr[ADDR_W-1:2];
        ram_wdata = lane_data[31:0];
        if (accept && legal_in && is_store_in) ram_we = lane_mask[3:0];
      end
      SPLIT: begin
        ram_addr = word_q + WW'(1);
        if (store_q && !rst) ram_we = hi_mask_q;
      end
      default: ;
    endcase
  end

  dm_ram #(.WORDS_W(WW)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  // Control FSM with registered handshake outputs and request capture.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            word_q    <= addr[ADDR_W-1:2];
            off_q     <= addr[1:0];
            f3_q      <= func3;
            store_q   <= is_store_in;
            split_q   <= split_in;
            hi_mask_q <= lane_mask[7:4];
            hi_data_q <= lane_data[63:32];
            err       <= !legal_in;
            req_ready <= 1'b0;
            if (split_in) begin
              state <= SPLIT;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end
          end
        end
        SPLIT: begin
          lo_q      <= ram_q;
          state     <= RESP;
          rsp_valid <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          err       <= 1'b0;
        end
      endcase
    end
  end

  // Load result: join captured words, align by byte offset, then extend.
  logic [63:0] pair;
  logic [63:0] shifted;
  logic [31:0] aligned;

  assign pair    = split_q ? {ram_q, lo_q} : {32'b0, ram_q};
  assign shifted = pair >> {off_q, 3'b000};
  assign aligned = shifted[31:0];

  // rdata is zero except on a legal load response.
  always_comb begin
    rdata = 32'b0;
    if (rsp_valid && !err && !store_q) begin
      case (f3_q)
        F3_LB:   rdata = {{24{aligned[7]}}, aligned[7:0]};
        F3_LH:   rdata = {{16{aligned[15]}}, aligned[15:0]};
        F3_LBU:  rdata = {24'b0, aligned[7:0]};
        F3_LHU:  rdata = {16'b0, aligned[15:0]};
        default: rdata = aligned;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: reset, aligned and split loads/stores,
// address wrap, illegal requests and reset during a split access.
module tb_data_mem_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  dm_w_en = 4'h0;
  logic [2:0]  func3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]  m;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          lat;
    logic        e;
  } vec_t;

  data_mem_unit #(.ADDR_W(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .dm_w_en   (dm_w_en),
    .func3     (func3),
    .addr      (addr),
    .wdata     (wdata),
    .rsp_valid (rsp_valid),
    .rdata     (rdata),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Issue one request and wait (bounded) for its response. Inputs are
  // scrambled while the access is in flight; lat=99 means no response.
  task automatic access(input vec_t v, output int lat, output logic [31:0] rd,
                        output logic e, output logic rdy_mid);
    @(negedge clk);
    req_valid = 1'b1;
    dm_w_en   = v.m;
    func3     = v.f3;
    addr      = v.a;
    wdata     = v.wd;
    lat       = 0;
    rdy_mid   = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) rdy_mid = req_ready;
      req_valid = 1'b0;
      addr      = $urandom;
      wdata     = $urandom;
      dm_w_en   = 4'hF;
      func3     = 3'b000;
    end while (!rsp_valid && lat < 8);
    if (rsp_valid) begin
      rd = rdata;
      e  = err;
    end else begin
      lat = 99;
      rd  = 32'hx;
      e   = 1'bx;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    rst = 1'b0;
  endtask

  // Aligned word store/load then sub-word loads and a byte store.
  task automatic test_aligned();
    vec_t v [9];
    int lat; logic [31:0] rd; logic e, rm;
    v[0] = '{4'hF, 3'b000, 32'h10, 32'hDEADBEEF, 32'h0,        1, 1'b0};
    v[1] = '{4'h0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1, 1'b0};
    v[2] = '{4'h0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 1, 1'b0};
    v[3] = '{4'h0, 3'b100, 32'h13, 32'h0,        32'h000000DE, 1, 1'b0};
    v[4] = '{4'h0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 1, 1'b0};
    v[5] = '{4'h0, 3'b101, 32'h10, 32'h0,        32'h0000BEEF, 1, 1'b0};
    v[6] = '{4'h0, 3'b001, 32'h10, 32'h0,        32'hFFFFBEEF, 1, 1'b0};
    v[7] = '{4'h1, 3'b000, 32'h11, 32'h0000007F, 32'h0,        1, 1'b0};
    v[8] = '{4'h0, 3'b010, 32'h10, 32'h0,        32'hDEAD7FEF, 1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      access(v[i], lat, rd, e, rm);
      n_cmp++; if (lat !== v[i].lat) begin n_bad++; $display("FAIL aligned[%0d] latency: got %0d want %0d", i, lat, v[i].lat); end
      n_cmp++; if (rd !== v[i].rd) begin n_bad++; $display("FAIL aligned[%0d] rdata: got %h want %h", i, rd, v[i].rd); end
      n_cmp++; if (e !== v[i].e) begin n_bad++; $display("FAIL aligned[%0d] err: got %b want %b", i, e, v[i].e); end
    end
  endtask

  // Misaligned word store across words 8/9, then split and single-word loads.
  task automatic test_split();
    vec_t v [8];
    int lat; logic [31:0] rd; logic e, rm;
    v[0] = '{4'hF, 3'b000, 32'h20, 32'h0,        32'h0,        1, 1'b0};
    v[1] = '{4'hF, 3'b000, 32'h24, 32'h0,        32'h0,        1, 1'b0};
    v[2] = '{4'hF, 3'b000, 32'h22, 32'h11223344, 32'h0,        2, 1'b0};
    v[3] = '{4'h0, 3'b010, 32'h20, 32'h0,        32'h33440000, 1, 1'b0};
    v[4] = '{4'h0, 3'b010, 32'h24, 32'h0,        32'h00001122, 1, 1'b0};
    v[5] = '{4'h0, 3'b010, 32'h22, 32'h0,        32'h11223344, 2, 1'b0};
    v[6] = '{4'h0, 3'b001, 32'h23, 32'h0,        32'h00002233, 2, 1'b0};
    v[7] = '{4'h0, 3'b000, 32'h23, 32'h0,        32'h00000033, 1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      access(v[i], lat, rd, e, rm);
      n_cmp++; if (lat !== v[i].lat) begin n_bad++; $display("FAIL split[%0d] latency: got %0d want %0d", i, lat, v[i].lat); end
      n_cmp++; if (rd !== v[i].rd) begin n_bad++; $display("FAIL split[%0d] rdata: got %h want %h", i, rd, v[i].rd); end
      n_cmp++; if (e !== v[i].e) begin n_bad++; $display("FAIL split[%0d] err: got %b want %b", i, e, v[i].e); end
      if (v[i].lat == 2) begin
        n_cmp++; if (rm !== 1'b0) begin n_bad++; $display("FAIL split[%0d] req_ready_mid: got %b want 0", i, rm); end
      end
    end
  endtask

  // Half store at the last byte wraps into byte 0 of word 0.
  task automatic test_wrap();
    vec_t v [5];
    int lat; logic [31:0] rd; logic e, rm;
    v[0] = '{4'h3, 3'b000, 32'h00000FFF, 32'h0000ABCD, 32'h0,        2, 1'b0};
    v[1] = '{4'h0, 3'b100, 32'h00000FFF, 32'h0,        32'h000000CD, 1, 1'b0};
    v[2] = '{4'h0, 3'b100, 32'h00000000, 32'h0,        32'h000000AB, 1, 1'b0};
    v[3] = '{4'h0, 3'b101, 32'h00000FFF, 32'h0,        32'h0000ABCD, 2, 1'b0};
    v[4] = '{4'h0, 3'b100, 32'hFFFFF000, 32'h0,        32'h000000AB, 1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      access(v[i], lat, rd, e, rm);
      n_cmp++; if (lat !== v[i].lat) begin n_bad++; $display("FAIL wrap[%0d] latency: got %0d want %0d", i, lat, v[i].lat); end
      n_cmp++; if (rd !== v[i].rd) begin n_bad++; $display("FAIL wrap[%0d] rdata: got %h want %h", i, rd, v[i].rd); end
      n_cmp++; if (e !== v[i].e) begin n_bad++; $display("FAIL wrap[%0d] err: got %b want %b", i, e, v[i].e); end
    end
  endtask

  // Illegal masks / func3 respond at accept+1 with err and leave memory alone.
  task automatic test_illegal();
    vec_t v [5];
    int lat; logic [31:0] rd; logic e, rm;
    v[0] = '{4'h5, 3'b000, 32'h10, 32'hFFFFFFFF, 32'h0,        1, 1'b1};
    v[1] = '{4'h7, 3'b000, 32'h12, 32'hFFFFFFFF, 32'h0,        1, 1'b1};
    v[2] = '{4'h0, 3'b011, 32'h10, 32'h0,        32'h0,        1, 1'b1};
    v[3] = '{4'h0, 3'b110, 32'h13, 32'h0,        32'h0,        1, 1'b1};
    v[4] = '{4'h0, 3'b010, 32'h10, 32'h0,        32'hDEAD7FEF, 1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      access(v[i], lat, rd, e, rm);
      n_cmp++; if (lat !== v[i].lat) begin n_bad++; $display("FAIL illegal[%0d] latency: got %0d want %0d", i, lat, v[i].lat); end
      n_cmp++; if (rd !== v[i].rd) begin n_bad++; $display("FAIL illegal[%0d] rdata: got %h want %h", i, rd, v[i].rd); end
      n_cmp++; if (e !== v[i].e) begin n_bad++; $display("FAIL illegal[%0d] err: got %b want %b", i, e, v[i].e); end
    end
  endtask

  // Reset in SPLIT keeps the first-word write and drops the second.
  task automatic test_reset_in_split();
    vec_t v;
    int lat; logic [31:0] rd; logic e, rm;
    bit seen;
    v = '{4'hF, 3'b000, 32'h30, 32'h0, 32'h0, 1, 1'b0};
    access(v, lat, rd, e, rm);
    v.a = 32'h34;
    access(v, lat, rd, e, rm);
    @(negedge clk);
    req_valid = 1'b1; dm_w_en = 4'hF; func3 = 3'b000;
    addr = 32'h31; wdata = 32'hAABBCCDD;
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_split in_split_ready: got %b want 0", req_ready); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_split ready_after: got %b want 1", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_split rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rst_split rdata: got %h want 0", rdata); end
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rst_split late_rsp: got %b want 0", seen); end
    v = '{4'h0, 3'b010, 32'h30, 32'h0, 32'hBBCCDD00, 1, 1'b0};
    access(v, lat, rd, e, rm);
    n_cmp++; if (rd !== v.rd) begin n_bad++; $display("FAIL rst_split word_w: got %h want %h", rd, v.rd); end
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL rst_split word_w_latency: got %0d want 1", lat); end
    v.a = 32'h34; v.rd = 32'h0;
    access(v, lat, rd, e, rm);
    n_cmp++; if (rd !== v.rd) begin n_bad++; $display("FAIL rst_split word_w1: got %h want %h", rd, v.rd); end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_split();
    test_wrap();
    test_illegal();
    test_reset_in_split();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
